// File: rtl/echo_display_scan.sv
// echo_display_scan
//   Time-multiplexed N-digit 7-segment driver. The host writes 5-bit echo
//   codes into a shadow buffer; a commit request copies the whole shadow
//   buffer into the active buffer at the next frame end, so the display
//   never shows a half-updated set of digits. Digits are scanned one at a
//   time with a prescaled counter, and each digit can blink at a rate set
//   in whole scan frames.
//
// Ports
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset
//   we      : shadow buffer write strobe
//   waddr   : shadow digit index (writes to indices >= N_DIG are ignored)
//   wdata   : echo code for that digit
//   commit  : one-cycle request to copy shadow -> active at next frame end
//   blink   : per-digit blink enable (bit i = digit i)
//   busy    : a commit is pending
//   an      : digit enables, one-hot active, polarity set by AN_LOW
//   seg     : segments {a,b,c,d,e,f,g}, active-high
module echo_display_scan #(
  parameter int N_DIG        = 4,
  parameter int PRESC        = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int AN_LOW       = 1,
  localparam int ADDR_W      = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [4:0]        wdata,
  input  logic              commit,
  input  logic [N_DIG-1:0]  blink,
  output logic              busy,
  output logic [N_DIG-1:0]  an,
  output logic [6:0]        seg
);

  localparam int PRESC_W = $clog2(PRESC);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
  localparam logic [ADDR_W-1:0]  DIG_LAST   = ADDR_W'(N_DIG - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  // XOR mask that turns the internal active-high one-hot into the pin polarity;
  // it is also the "all digits off" value.
  localparam logic [N_DIG-1:0]   AN_OFF     = (AN_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};
  localparam logic [4:0]         CODE_BLANK = 5'h10;

  typedef enum logic {IDLE, PEND} state_t;

  state_t             state, state_next;
  logic [PRESC_W-1:0] presc_cnt;
  logic [ADDR_W-1:0]  dig;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_off;
  logic               tick;
  logic               frame_end;
  logic               copy;
  logic               addr_ok;
  logic [4:0]         shadow [N_DIG];
  logic [4:0]         active [N_DIG];
  logic [4:0]         cur_code;
  logic [N_DIG-1:0]   dig_onehot;
  logic               blank;

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'h00:   decode = 7'h7E;
      5'h01:   decode = 7'h30;
      5'h02:   decode = 7'h6D;
      5'h03:   decode = 7'h79;
      5'h04:   decode = 7'h33;
      5'h05:   decode = 7'h5B;
      5'h06:   decode = 7'h5F;
      5'h07:   decode = 7'h70;
      5'h08:   decode = 7'h7F;
      5'h09:   decode = 7'h7B;
      5'h0A:   decode = 7'h77;
      5'h0B:   decode = 7'h1F;
      5'h0C:   decode = 7'h4E;
      5'h0D:   decode = 7'h3D;
      5'h0E:   decode = 7'h4F;
      5'h0F:   decode = 7'h47;
      5'h11:   decode = 7'h01;
      default: decode = 7'h00;
    endcase
  endfunction

  assign tick      = (presc_cnt == PRESC_LAST);
  assign frame_end = tick && (dig == DIG_LAST);

  // When N_DIG is a power of two every address is a real digit, so the range
  // check collapses to a constant instead of a comparison that is always true.
  if (N_DIG == (1 << ADDR_W)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    localparam logic [ADDR_W:0] N_DIG_W = (ADDR_W + 1)'(N_DIG);
    assign addr_ok = ({1'b0, waddr} < N_DIG_W);
  end

  // Prescaler: one digit slot lasts PRESC clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + 1'b1;
  end

  // Digit scan index, advanced once per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dig <= '0;
    else if (tick) dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
  end

  // Blink timing: the phase flips every BLINK_FRAMES complete scan frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Commit FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Commit FSM: next state. A request arriving on a frame end while idle only
  // arms the copy; it is performed at the following frame end.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit)    state_next = PEND;
      PEND:    if (frame_end) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Commit FSM: outputs.
  always_comb begin
    busy = (state == PEND);
    copy = (state == PEND) && frame_end;
  end

  // Shadow buffer, written only by the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIG; i++) shadow[i] <= CODE_BLANK;
    end else if (we && addr_ok) begin
      shadow[waddr] <= wdata;
    end
  end

  // Active buffer: whole-buffer copy samples the shadow before any write
  // landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIG; i++) active[i] <= CODE_BLANK;
    end else if (copy) begin
      for (int i = 0; i < N_DIG; i++) active[i] <= shadow[i];
    end
  end

  always_comb begin
    cur_code        = active[dig];
    dig_onehot      = '0;
    dig_onehot[dig] = 1'b1;
    blank           = blink_off && blink[dig];
  end

  // Registered pin drivers so the digit enable and its segments switch on the
  // same edge, with no intermediate states visible on the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= 7'h00;
    end else begin
      an  <= dig_onehot ^ AN_OFF;
      seg <= blank ? 7'h00 : decode(cur_code);
    end
  end

endmodule

// File: tb/tb_echo_display_scan.sv
// tb_echo_display_scan
//   Bench for echo_display_scan with a 4-digit, fast-scan configuration
//   (frame = 16 clocks, blink half-period = 2 frames) plus a 3-digit
//   instance for the out-of-range write address case. The reference keeps
//   the buffers as plain arrays and derives the scanned digit, frame end
//   and blink phase from a cycle count since reset release.
module tb_echo_display_scan;

  localparam int N_DIG        = 4;
  localparam int PRESC        = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = PRESC * N_DIG;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [1:0] waddr;
  logic [4:0] wdata;
  logic       commit;
  logic [3:0] blink;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;

  logic       rst3_n;
  logic       we3;
  logic [1:0] waddr3;
  logic [4:0] wdata3;
  logic       commit3;
  logic [2:0] blink3;
  logic       busy3;
  logic [2:0] an3;
  logic [6:0] seg3;

  int checks = 0;
  int passes = 0;

  logic [4:0] m_shadow [N_DIG];
  logic [4:0] m_active [N_DIG];
  bit         m_pend;
  int         s;

  echo_display_scan #(
    .N_DIG(N_DIG), .PRESC(PRESC), .BLINK_FRAMES(BLINK_FRAMES), .AN_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .commit(commit), .blink(blink), .busy(busy), .an(an), .seg(seg)
  );

  echo_display_scan #(
    .N_DIG(3), .PRESC(PRESC), .BLINK_FRAMES(BLINK_FRAMES), .AN_LOW(1)
  ) dut3 (
    .clk(clk), .rst_n(rst3_n), .we(we3), .waddr(waddr3), .wdata(wdata3),
    .commit(commit3), .blink(blink3), .busy(busy3), .an(an3), .seg(seg3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [4:0] code);
    case (code)
      5'h00: ref_seg = 7'h7E;  5'h01: ref_seg = 7'h30;
      5'h02: ref_seg = 7'h6D;  5'h03: ref_seg = 7'h79;
      5'h04: ref_seg = 7'h33;  5'h05: ref_seg = 7'h5B;
      5'h06: ref_seg = 7'h5F;  5'h07: ref_seg = 7'h70;
      5'h08: ref_seg = 7'h7F;  5'h09: ref_seg = 7'h7B;
      5'h0A: ref_seg = 7'h77;  5'h0B: ref_seg = 7'h1F;
      5'h0C: ref_seg = 7'h4E;  5'h0D: ref_seg = 7'h3D;
      5'h0E: ref_seg = 7'h4F;  5'h0F: ref_seg = 7'h47;
      5'h11: ref_seg = 7'h01;
      default: ref_seg = 7'h00;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, s);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_DIG; i++) begin
      m_shadow[i] = 5'h10;
      m_active[i] = 5'h10;
    end
    m_pend = 1'b0;
    s      = 0;
  endtask

  // One clock of stimulus: predicts the registered outputs from the state
  // before the edge, advances the reference, then checks after the edge.
  task automatic apply_stimulus();
    int         d;
    bit         off;
    bit         fe;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    d     = (s / PRESC) % N_DIG;
    off   = (((s / FRAME) / BLINK_FRAMES) % 2) == 1;
    e_an  = ~(4'b0001 << d);
    e_seg = (off && blink[d]) ? 7'h00 : ref_seg(m_active[d]);
    fe    = (s % FRAME) == FRAME - 1;
    if (m_pend && fe) begin
      for (int i = 0; i < N_DIG; i++) m_active[i] = m_shadow[i];
      m_pend = 1'b0;
    end else if (!m_pend && commit) begin
      m_pend = 1'b1;
    end
    if (we && (int'(waddr) < N_DIG)) m_shadow[waddr] = wdata;
    s++;
    @(posedge clk);
    #1;
    check_output("an", 8'(an), 8'(e_an));
    check_output("seg", 8'(seg), 8'(e_seg));
    check_output("busy", 8'(busy), 8'(m_pend));
  endtask

  initial begin
    logic [2:0] e3;
    int         d3;
    rst_n = 1'b1; rst3_n = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0; commit = 1'b0; blink = '0;
    we3 = 1'b0; waddr3 = '0; wdata3 = '0; commit3 = 1'b0; blink3 = '0;
    model_reset();
    #1;
    rst_n = 1'b0; rst3_n = 1'b0;
    #1;
    check_output("reset_an", 8'(an), 8'h0F);
    check_output("reset_seg", 8'(seg), 8'h00);
    check_output("reset_busy", 8'(busy), 8'h00);
    check_output("reset3_an", 8'(an3), 8'h07);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle scan with a blank display.
    repeat (2 * FRAME) apply_stimulus();

    // Shadow writes stay invisible until committed.
    for (int i = 0; i < N_DIG; i++) begin
      we = 1'b1; waddr = 2'(i); wdata = 5'(i + 1);
      apply_stimulus();
    end
    we = 1'b0;
    repeat (20) apply_stimulus();
    commit = 1'b1; apply_stimulus(); commit = 1'b0;
    repeat (2 * FRAME) apply_stimulus();

    // Write landing on the copy edge: the copy takes the old value.
    commit = 1'b1; apply_stimulus(); commit = 1'b0;
    for (int k = 0; k < FRAME && (s % FRAME) != FRAME - 1; k++) apply_stimulus();
    we = 1'b1; waddr = 2'd0; wdata = 5'h11; apply_stimulus(); we = 1'b0;
    repeat (FRAME) apply_stimulus();
    commit = 1'b1; apply_stimulus(); commit = 1'b0;
    repeat (2 * FRAME) apply_stimulus();

    // Commit raised exactly on a frame end while idle.
    for (int k = 0; k < FRAME && (s % FRAME) != FRAME - 1; k++) apply_stimulus();
    we = 1'b1; waddr = 2'd1; wdata = 5'h0A; commit = 1'b1; apply_stimulus();
    we = 1'b0; commit = 1'b0;
    repeat (2 * FRAME) apply_stimulus();

    // Blink on digit 0 showing 8.
    we = 1'b1; waddr = 2'd0; wdata = 5'h08; apply_stimulus(); we = 1'b0;
    commit = 1'b1; apply_stimulus(); commit = 1'b0;
    repeat (FRAME) apply_stimulus();
    blink = 4'b0001;
    repeat (6 * FRAME) apply_stimulus();
    blink = 4'b0000;

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      we     = 1'($urandom_range(0, 1));
      waddr  = 2'($urandom_range(0, 3));
      wdata  = 5'($urandom);
      commit = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) blink = 4'($urandom);
      apply_stimulus();
    end
    we = 1'b0; commit = 1'b0; blink = '0;

    // Reset while a commit is pending.
    for (int k = 0; k < FRAME && (s % FRAME) != 2; k++) apply_stimulus();
    we = 1'b1; waddr = 2'd2; wdata = 5'h05; apply_stimulus(); we = 1'b0;
    commit = 1'b1; apply_stimulus(); commit = 1'b0;
    apply_stimulus();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midreset_an", 8'(an), 8'h0F);
    check_output("midreset_seg", 8'(seg), 8'h00);
    check_output("midreset_busy", 8'(busy), 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2 * FRAME) apply_stimulus();

    // Three-digit instance: address 3 does not exist and must be ignored.
    @(negedge clk);
    rst3_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      we3     = (k < 4);
      waddr3  = 2'(k);
      wdata3  = (k == 3) ? 5'h08 : 5'(k + 1);
      commit3 = (k == 4);
      d3      = (k / PRESC) % 3;
      e3      = 3'b001 << d3;
      e3      = ~e3;
      @(posedge clk);
      #1;
      check_output("dut3_an", 8'(an3), 8'(e3));
      if (k >= 20) check_output("dut3_seg", 8'(seg3), 8'(ref_seg(5'(d3 + 1))));
    end
    check_output("dut3_busy", 8'(busy3), 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
